// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and move arbiter for the 3x3 tic-tac-toe board.
// Accepts X/O move requests, checks legality, drives the board's set/reset
// and keeps saturating win/draw tallies.
// Optional build macro TTT_TIMEOUT_EN adds a per-move timer with forfeit.
module ttt_game_ctrl #(
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               x_req,
  input  logic [1:0]         x_row,
  input  logic [1:0]         x_col,
  input  logic               o_req,
  input  logic [1:0]         o_row,
  input  logic [1:0]         o_col,
  output logic               x_ack,
  output logic               x_rej,
  output logic               o_ack,
  output logic               o_rej,
  input  logic               new_game,
  output logic               board_set,
  output logic               board_reset,
  output logic [1:0]         board_row,
  output logic [1:0]         board_col,
  input  logic [8:0]         board_valid,
  input  logic [1:0]         board_game_state,
  output logic               turn,
  output logic               game_over,
  output logic [1:0]         result,
  output logic               forfeit,
  output logic [SCORE_W-1:0] x_wins,
  output logic [SCORE_W-1:0] o_wins,
  output logic [SCORE_W-1:0] draws
);

  localparam int unsigned COORD_W = 2;
  localparam int unsigned CELLS   = 9;
  localparam int unsigned GS_W    = 2;
  localparam int unsigned LIN_W   = 4;

  localparam logic [GS_W-1:0] GS_PLAY = 2'b00;
  localparam logic [GS_W-1:0] GS_X    = 2'b01;
  localparam logic [GS_W-1:0] GS_O    = 2'b10;
  localparam logic [GS_W-1:0] GS_DRAW = 2'b11;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT,
    S_CHECK,
    S_ISSUE,
    S_SETTLE,
    S_RELEASE,
    S_GAME_OVER
  } state_t;

  // The time limit must leave at least one idle cycle in WAIT.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t state, state_nxt;

  logic               turn_nxt, game_over_nxt, board_set_nxt, board_reset_nxt;
  logic               x_ack_nxt, x_rej_nxt, o_ack_nxt, o_rej_nxt;
  logic [GS_W-1:0]    result_nxt;
  logic [COORD_W-1:0] board_row_nxt, board_col_nxt;
  logic [SCORE_W-1:0] x_wins_nxt, o_wins_nxt, draws_nxt;
  logic               tally_en;

  logic               cur_req_c;
  logic [COORD_W-1:0] cur_row_c, cur_col_c;
  logic               coord_bad_c, occupied_c;
  logic [LIN_W-1:0]   lin_c;
  logic [CELLS-1:0]   cell_mask_c;

`ifdef TTT_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               timeout_c;
  logic               forfeit_nxt;
  assign timeout_c = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
  assign forfeit = 1'b0;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

  // Current player's request and coordinates, plus occupancy of the captured cell.
  always_comb begin
    cur_req_c   = turn ? x_req : o_req;
    cur_row_c   = turn ? x_row : o_row;
    cur_col_c   = turn ? x_col : o_col;
    coord_bad_c = (board_row == '0) || (board_col == '0);
    lin_c       = LIN_W'(board_row - 2'd1) * LIN_W'(3) + LIN_W'(board_col - 2'd1);
    cell_mask_c = 9'h100 >> lin_c;
    occupied_c  = |(board_valid & cell_mask_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    turn_nxt      = turn;
    result_nxt    = result;
    board_row_nxt = board_row;
    board_col_nxt = board_col;
    x_wins_nxt    = x_wins;
    o_wins_nxt    = o_wins;
    draws_nxt     = draws;
    x_ack_nxt     = 1'b0;
    x_rej_nxt     = 1'b0;
    o_ack_nxt     = 1'b0;
    o_rej_nxt     = 1'b0;
    board_set_nxt = 1'b0;
    tally_en      = 1'b0;
`ifdef TTT_TIMEOUT_EN
    forfeit_nxt   = 1'b0;
`endif

    case (state)
      S_CLEAR: begin
        turn_nxt   = 1'b1;
        result_nxt = GS_PLAY;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (new_game) begin
          state_nxt = S_CLEAR;
        end else if (cur_req_c) begin
          board_row_nxt = cur_row_c;
          board_col_nxt = cur_col_c;
          state_nxt     = S_CHECK;
        end
`ifdef TTT_TIMEOUT_EN
        else if (timeout_c) begin
          forfeit_nxt = 1'b1;
          result_nxt  = turn ? GS_O : GS_X;
          tally_en    = 1'b1;
          state_nxt   = S_GAME_OVER;
        end
`endif
      end
      S_CHECK: begin
        if (coord_bad_c || occupied_c) begin
          x_rej_nxt = turn;
          o_rej_nxt = !turn;
          state_nxt = S_RELEASE;
        end else begin
          x_ack_nxt     = turn;
          o_ack_nxt     = !turn;
          board_set_nxt = 1'b1;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (board_game_state != GS_PLAY) begin
          result_nxt = board_game_state;
          tally_en   = 1'b1;
          state_nxt  = S_GAME_OVER;
        end else begin
          turn_nxt  = !turn;
          state_nxt = S_WAIT;
        end
      end
      S_RELEASE: begin
        if (!cur_req_c) state_nxt = S_WAIT;
      end
      S_GAME_OVER: begin
        if (new_game) state_nxt = S_CLEAR;
      end
      default: begin
        state_nxt = S_CLEAR;
      end
    endcase

    if (tally_en) begin
      case (result_nxt)
        GS_X:    x_wins_nxt = sat_inc(x_wins);
        GS_O:    o_wins_nxt = sat_inc(o_wins);
        GS_DRAW: draws_nxt  = sat_inc(draws);
        default: ;
      endcase
    end

    board_reset_nxt = (state_nxt == S_CLEAR);
    game_over_nxt   = (state_nxt == S_GAME_OVER);

`ifdef TTT_TIMEOUT_EN
    // Zero outside WAIT so every entry into WAIT starts a fresh move window.
    timer_nxt = (state != S_WAIT) ? '0 : timer + TIMER_W'(1);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CLEAR;
      board_reset <= 1'b1;
      turn        <= 1'b1;
      board_set   <= 1'b0;
      board_row   <= '0;
      board_col   <= '0;
      game_over   <= 1'b0;
      result      <= GS_PLAY;
      x_ack       <= 1'b0;
      x_rej       <= 1'b0;
      o_ack       <= 1'b0;
      o_rej       <= 1'b0;
      x_wins      <= '0;
      o_wins      <= '0;
      draws       <= '0;
`ifdef TTT_TIMEOUT_EN
      timer       <= '0;
      forfeit     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      board_reset <= board_reset_nxt;
      turn        <= turn_nxt;
      board_set   <= board_set_nxt;
      board_row   <= board_row_nxt;
      board_col   <= board_col_nxt;
      game_over   <= game_over_nxt;
      result      <= result_nxt;
      x_ack       <= x_ack_nxt;
      x_rej       <= x_rej_nxt;
      o_ack       <= o_ack_nxt;
      o_rej       <= o_rej_nxt;
      x_wins      <= x_wins_nxt;
      o_wins      <= o_wins_nxt;
      draws       <= draws_nxt;
`ifdef TTT_TIMEOUT_EN
      timer       <= timer_nxt;
      forfeit     <= forfeit_nxt;
`endif
    end
  end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Turn sequencer and move arbiter for the 3x3 tic-tac-toe board block. It accepts move requests from two player ports (X and O), enforces turn order and legality, and drives the board's `set`/`row`/`col`/`reset` inputs. It watches the board's `valid` and `game_state` outputs, latches the result and keeps saturating win/draw tallies. It sits between the player front-ends and the board; the board is instantiated alongside it, not inside it.

## Interface
- `SCORE_W`, 8: width of each tally counter.
- `TIMEOUT_CYCLES`, 1000: per-move time limit in clocks; used only with `TTT_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `x_req`, `o_req` in 1: move request, level. Hold until `*_ack` or `*_rej`.
- `x_row`, `x_col`, `o_row`, `o_col` in 2: move coordinates. Legal values are 1..3; 0 is illegal.
- `x_ack`, `o_ack` out 1: one-cycle pulse, move accepted.
- `x_rej`, `o_rej` out 1: one-cycle pulse, move rejected (coordinate 0 or cell occupied).
- `new_game` in 1: level; clear the board and start a game.
- `board_set`, `board_reset` out 1: drive the board's `set` and `reset` inputs.
- `board_row`, `board_col` out 2: drive the board's `row` and `col` inputs.
- `board_valid` in 9: board occupancy. Cell (r,c) maps to bit `8-((r-1)*3+(c-1))`.
- `board_game_state` in 2: 00 in play, 01 X wins, 10 O wins, 11 draw.
- `turn` out 1: 1 = X to move, 0 = O to move.
- `game_over` out 1: high while in GAME_OVER.
- `result` out 2: latched outcome, same encoding as `board_game_state`.
- `forfeit` out 1: one-cycle pulse on a timeout loss.
- `x_wins`, `o_wins`, `draws` out `SCORE_W`: saturating tallies.

## Operation
- States: CLEAR, WAIT, CHECK, ISSUE, SETTLE, RELEASE, GAME_OVER.
- **CLEAR**
  - `board_reset`=1 for one cycle.
  - Sets `turn`=1, clears `result`, clears the move timer.
  - Always goes to WAIT.
- **WAIT**
  - `new_game`=1 → CLEAR. This has priority over requests and abandons the game; no tally changes.
  - Otherwise, if the current player's `*_req`=1: capture that player's row/col and go to CHECK.
  - The off-turn player's request is ignored and left pending, with no ack or rej.
- **CHECK**
  - If row=0, col=0, or the addressed `board_valid` bit is 1: pulse `*_rej` and go to RELEASE.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `board_set`=1 for exactly one cycle, with `board_row`/`board_col` holding the captured value.
  - Pulse `*_ack` in the same cycle.
  - Go to SETTLE.
- **SETTLE**
  - `board_game_state` reflects the new move.
  - If non-zero: latch it into `result`, increment the matching tally, go to GAME_OVER.
  - Otherwise toggle `turn` and go to WAIT.
- **RELEASE**
  - Wait until the rejected player's `*_req`=0, then go to WAIT. `turn` is unchanged.
- **GAME_OVER**
  - Hold `result`; ignore all requests.
  - `new_game`=1 → CLEAR.
- `new_game` is sampled only in WAIT and GAME_OVER.
- Tallies saturate at 2^`SCORE_W`-1 and are cleared only by `reset_n`.
- Players deassert `*_req` the cycle after receiving `*_ack`.

## Timing
- Reset values:
  - State CLEAR.
  - `board_reset`=1; all other outputs 0 except `turn`=1.
  - Tallies 0.
  - The board is cleared on the first clock edge after `reset_n` rises.
- Latency: request seen in WAIT at edge t → CHECK at t+1 → `*_ack` and `board_set` high during cycle t+2 → board updated at edge t+3 → SETTLE decision at edge t+4.
- Rejection: `*_rej` is high during cycle t+2.
- All outputs are registered. `board_set` is never high in two consecutive cycles.
- If `reset_n` is asserted mid-move (any state), the FSM goes to CLEAR immediately and `board_set` drops to 0 asynchronously.

## Configuration
- `TTT_TIMEOUT_EN` defined:
  - A move timer counts cycles in WAIT and is cleared on entry to WAIT.
  - When it reaches `TIMEOUT_CYCLES`-1 with no request captured, the current player forfeits:
    - `result` = opponent win (01 or 10), and the opponent's tally increments.
    - `forfeit` pulses for one cycle.
    - FSM goes to GAME_OVER.
  - `new_game` in the same cycle takes priority over the timeout.
- `TTT_TIMEOUT_EN` not defined: no timer is built, WAIT waits indefinitely, and `forfeit` is tied to 0.

## Test plan
- Reset release: `board_reset`=1 for one cycle, then WAIT with `turn`=1, `result`=00, tallies 0.
- X plays (1,1),(1,2),(1,3); O plays (2,1),(2,2):
  - each move acked at request+2;
  - `result`=01, `x_wins`=1, `game_over`=1.
- Illegal moves:
  - X requests (0,2) → `x_rej`, `turn` stays 1;
  - O requests a cell occupied by X → `o_rej`;
  - `o_req` asserted during X's turn → no ack until X moves.
- Full-board draw sequence → `result`=11, `draws`=1; `new_game` then clears the board and returns `turn`=1.
- With `TTT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: X idle 16 cycles → `forfeit` pulse, `result`=10, `o_wins`=1.
- `reset_n` low during ISSUE → `board_set` drops to 0 immediately; after release, the board is cleared and tallies are 0.
